// File: rtl/regfile32x32.sv
// 32 x WIDTH general-purpose register file: one synchronous write port, two
// forwarding combinational read ports, one raw debug read port, write counter.
module regfile32x32 #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [4:0]       WA,
  input  logic [WIDTH-1:0] WD,
  input  logic [4:0]       RA1,
  input  logic [4:0]       RA2,
  input  logic [4:0]       DA,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  output logic [WIDTH-1:0] DD,
  output logic [31:0]      WCNT
);

  logic [WIDTH-1:0] r_reg [32];
  logic [31:0]      wcnt_reg;
  logic [31:0]      wsel;
  logic             commit;
  logic             fwd1;
  logic             fwd2;

  // A write to the hardwired zero register is not a commit: no store, no count, no forward.
  assign commit = !RST && WE && !(ZERO_REG && (WA == 5'd0));
  assign fwd1   = commit && (WA == RA1);
  assign fwd2   = commit && (WA == RA2);

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_dec
      assign wsel[gi] = commit && (WA == 5'(gi));
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) begin
        r_reg[i] <= '0;
      end
      wcnt_reg <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (wsel[i]) begin
          r_reg[i] <= WD;
        end
      end
      if (commit) begin
        wcnt_reg <= wcnt_reg + 32'd1;
      end
    end
  end

  always_comb begin
    RD1 = r_reg[RA1];
    if (fwd1) begin
      RD1 = WD;
    end
    if (ZERO_REG && (RA1 == 5'd0)) begin
      RD1 = '0;
    end
  end

  always_comb begin
    RD2 = r_reg[RA2];
    if (fwd2) begin
      RD2 = WD;
    end
    if (ZERO_REG && (RA2 == 5'd0)) begin
      RD2 = '0;
    end
  end

  always_comb begin
    DD = r_reg[DA];
    if (ZERO_REG && (DA == 5'd0)) begin
      DD = '0;
    end
  end

  assign WCNT = wcnt_reg;

endmodule

// File: tb/tb_regfile32x32.sv
// Directed bench for regfile32x32: one instance with a hardwired zero
// register and one where register 0 is ordinary, both driven identically.
module tb_regfile32x32;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  da;
  logic [31:0] rd1, rd2, dd, wcnt;
  logic [31:0] rd1_nz, rd2_nz, dd_nz, wcnt_nz;

  int n_checks = 0;
  int n_fail   = 0;

  regfile32x32 #(.WIDTH(32), .ZERO_REG(1'b1)) dut (
    .CLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd),
    .RA1(ra1), .RA2(ra2), .DA(da),
    .RD1(rd1), .RD2(rd2), .DD(dd), .WCNT(wcnt)
  );

  regfile32x32 #(.WIDTH(32), .ZERO_REG(1'b0)) dut_nz (
    .CLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd),
    .RA1(ra1), .RA2(ra2), .DA(da),
    .RD1(rd1_nz), .RD2(rd2_nz), .DD(dd_nz), .WCNT(wcnt_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("pass %s: %08h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    logic [31:0] exp;
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; da = '0;
    tick();
    tick();
    rst = 1'b0;
    ra1 = 5'd5; ra2 = 5'd31; da = 5'd5;
    #1;
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    check("reset_dd", dd, 32'h0);
    check("reset_wcnt", wcnt, 32'h0);

    // Reset clear after preload
    write(5'd5, 32'h0000_1234);
    write(5'd31, 32'hFFFF_FFFF);
    #1;
    check("preload_rd1", rd1, 32'h0000_1234);
    check("preload_rd2", rd2, 32'hFFFF_FFFF);
    check("preload_wcnt", wcnt, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("clear_rd1", rd1, 32'h0);
    check("clear_rd2", rd2, 32'h0);
    check("clear_wcnt", wcnt, 32'h0);

    // Basic write/read
    write(5'd7, 32'hDEAD_BEEF);
    ra1 = 5'd7; da = 5'd7;
    #1;
    check("basic_rd1", rd1, 32'hDEAD_BEEF);
    check("basic_dd", dd, 32'hDEAD_BEEF);
    check("basic_wcnt", wcnt, 32'd1);

    // Register zero, both flavours
    we = 1'b1; wa = 5'd0; wd = 32'hAAAA_5555; ra1 = 5'd0;
    #1;
    check("r0_pre_rd1", rd1, 32'h0);
    check("r0nz_pre_rd1", rd1_nz, 32'hAAAA_5555);
    tick();
    we = 1'b0;
    #1;
    check("r0_post_rd1", rd1, 32'h0);
    check("r0_post_wcnt", wcnt, 32'd1);
    check("r0nz_post_rd1", rd1_nz, 32'hAAAA_5555);
    check("r0nz_post_wcnt", wcnt_nz, 32'd2);

    // Forwarding
    write(5'd3, 32'h11);
    we = 1'b1; wa = 5'd3; wd = 32'h22; ra1 = 5'd3; ra2 = 5'd3; da = 5'd3;
    #1;
    check("fwd_rd1", rd1, 32'h22);
    check("fwd_rd2", rd2, 32'h22);
    check("fwd_dd", dd, 32'h11);
    tick();
    we = 1'b0;
    #1;
    check("fwd_post_dd", dd, 32'h22);
    check("fwd_post_wcnt", wcnt, 32'd3);

    // Reset collision
    write(5'd9, 32'h77);
    rst = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'h55; ra1 = 5'd9; da = 5'd9;
    #1;
    check("rstcol_pre_rd1", rd1, 32'h77);
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
    check("rstcol_rd1", rd1, 32'h0);
    check("rstcol_dd", dd, 32'h0);
    check("rstcol_wcnt", wcnt, 32'h0);

    // Reset held several cycles ignores WE
    rst = 1'b1; we = 1'b1; wa = 5'd4; wd = 32'h99; ra1 = 5'd4;
    tick();
    tick();
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
    check("rsthold_rd1", rd1, 32'h0);
    check("rsthold_wcnt", wcnt, 32'h0);

    // Full sweep, back-to-back
    for (int i = 1; i < 32; i++) begin
      we = 1'b1;
      wa = 5'(i);
      wd = 32'(i) * 32'h0101_0101;
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i); da = 5'(i);
      #1;
      exp = 32'(i) * 32'h0101_0101;
      check($sformatf("sweep_rd1_%0d", i), rd1, exp);
      check($sformatf("sweep_dd_%0d", i), dd, exp);
      exp = 32'(31 - i) * 32'h0101_0101;
      check($sformatf("sweep_rd2_%0d", 31 - i), rd2, exp);
    end
    check("sweep_wcnt", wcnt, 32'd31);

    // Back-to-back writes to one address keep the last value
    write(5'd2, 32'h1);
    write(5'd2, 32'h2);
    ra1 = 5'd2;
    #1;
    check("b2b_rd1", rd1, 32'h2);
    check("b2b_wcnt", wcnt, 32'd33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
